// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//
// Purpose:
//   Arbitrates register-file write-back between the ALU result path and the
//   load (data-memory) path onto the single register-file write port. The
//   arbiter is round-robin with one grant per cycle. The write port is
//   registered, so a request accepted in cycle N is written in cycle N+1.
//   Writes to x0 complete their handshake but never raise rWrite.
//
// Optional feature (macro WB_SCOREBOARD_EN):
//   When the macro is defined, the block keeps one busy bit per register.
//   issue_valid/issue_rd set a busy bit, and a write-back transfer clears it.
//   stall reports a pending source operand to decode. When the macro is
//   undefined, no busy storage is built and stall is tied to 0. The port list
//   is the same in both builds.
//
// Ports:
//   clock, reset          rising-edge clock; asynchronous active-low reset
//   alu_valid/ready/rd/data  ALU write-back requester
//   mem_valid/ready/rd/data  load write-back requester
//   rWrite, rsWrite, dataWrite  registered register-file write port
//   last_grant            requester of the last transfer (0 = ALU, 1 = MEM)
//   issue_valid, issue_rd decode issues a producer of issue_rd
//   rs1, rs2              decode source operands
//   stall                 a source operand is still pending write-back
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. ready is high only for the granted requester and may depend on
// valid. A requester must not make valid depend on ready. It must hold valid,
// rd and data stable until it sees ready.

module regfile_write_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  rWrite,
    output logic [ADDR_WIDTH-1:0] rsWrite,
    output logic [DATA_WIDTH-1:0] dataWrite,
    output logic                  last_grant,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  stall
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic                  gnt_alu;
    logic                  gnt_mem;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // Round-robin grant. When both requesters are valid, the requester that
    // did not win last time is granted. last_grant resets to MEM, so ALU
    // wins the first contended cycle. Grants are gated by reset so that ready
    // stays low for the whole time reset is asserted.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if (reset) begin
            if (alu_valid && mem_valid) begin
                gnt_alu = last_grant;
                gnt_mem = ~last_grant;
            end else begin
                gnt_alu = alu_valid;
                gnt_mem = mem_valid;
            end
        end
    end

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;
    assign xfer      = gnt_alu | gnt_mem;
    assign sel_rd    = gnt_mem ? mem_rd   : alu_rd;
    assign sel_data  = gnt_mem ? mem_data : alu_data;

    // Registered write port. Index and data hold between transfers. The
    // enable is a single-cycle pulse for each transfer that is not to x0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rWrite     <= 1'b0;
            rsWrite    <= '0;
            dataWrite  <= '0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            rWrite     <= (sel_rd != '0);
            rsWrite    <= sel_rd;
            dataWrite  <= sel_data;
            last_grant <= gnt_mem;
        end else begin
            rWrite     <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    // Busy bit per register. Bit 0 is never set, so it stays at its reset
    // value of 0.
    logic [NUM_REGS-1:0] busy;

    // The clear is written before the set, so a same-cycle issue to the
    // register being retired leaves it busy. The newer producer is still
    // outstanding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (xfer && (sel_rd != '0)) begin
                busy[sel_rd] <= 1'b0;
            end
            if (issue_valid && (issue_rd != '0)) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

    // stall uses only the registered busy bits. A clear in the same cycle is
    // not forwarded, so decode waits one extra cycle after the write-back.
    assign stall = ((rs1 != '0) && busy[rs1]) || ((rs2 != '0) && busy[rs2]);
`else
    // Scoreboard inputs are deliberately ignored in this build.
    logic unused_sb_inputs;
    assign unused_sb_inputs = &{1'b0, issue_valid, issue_rd, rs1, rs2};
    assign stall = 1'b0;
`endif

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
Arbitrates register-file write-back between two requesters, the ALU result path and the load (data-memory) path, onto the single register-file write port (rWrite / rsWrite / dataWrite). Uses round-robin arbitration with a valid/ready handshake per requester. Drives a registered write port with 1-cycle latency and suppresses writes to x0. Optionally keeps a busy scoreboard per register, which generates a read-operand stall for the decode stage.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers, index 0 hard-wired zero)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
alu_valid  input  1  ALU write-back request
alu_ready  output  1  ALU request granted this cycle
alu_rd  input  ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU write data
mem_valid  input  1  load write-back request
mem_ready  output  1  load request granted this cycle
mem_rd  input  ADDR_WIDTH  load destination register
mem_data  input  DATA_WIDTH  load write data
rWrite  output  1  register-file write enable (registered)
rsWrite  output  ADDR_WIDTH  register-file write index (registered)
dataWrite  output  DATA_WIDTH  register-file write data (registered)
last_grant  output  1  requester of last transfer: 0 = ALU, 1 = MEM
issue_valid  input  1  decode issues an instruction that writes issue_rd
issue_rd  input  ADDR_WIDTH  destination of the issued instruction
rs1  input  ADDR_WIDTH  decode source register 1
rs2  input  ADDR_WIDTH  decode source register 2
stall  output  1  a source operand is pending write-back

Behaviour:
- Reset (reset=0, async):
  - rWrite=0, rsWrite=0, dataWrite=0, last_grant=1, all busy bits 0.
  - alu_ready=0 and mem_ready=0 while reset is low.
  - Reset asserted mid-operation drops rWrite immediately. Any in-flight handshake is lost.
- Grant rule (combinational, one grant per cycle):
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not last_grant.
  - Neither valid: no grant.
- ready is 1 only for the granted requester. It may depend on valid, but requesters must not make valid depend on ready.
- A requester holds valid, rd and data stable until it sees ready.
- Transfer = valid && ready. On the transfer edge:
  - rsWrite <= rd and dataWrite <= data.
  - rWrite <= (rd != 0).
  - last_grant <= the granted requester.
- rd==0 transfers complete the handshake and update last_grant, but issue no write (rWrite=0).
- No transfer in a cycle: rWrite <= 0 next edge. rsWrite and dataWrite hold their values.
- Latency: request accepted in cycle N, rWrite is high in cycle N+1 for exactly one cycle per transfer.
- Back-to-back transfers give continuous rWrite=1 with new index and data each cycle.
- Throughput is 1 write per cycle. Under sustained dual requests, the strict alternation is ALU, MEM, ALU, ... (ALU first after reset).
- Scoreboard (see Optional Feature):
  - busy[i] for i = 1..2**ADDR_WIDTH-1; busy[0] is constant 0.
  - issue_valid with issue_rd != 0 sets busy[issue_rd] at the edge.
  - A transfer with rd != 0 clears busy[rd] at the same edge the write is registered.
  - Simultaneous set and clear of the same index: set wins (newer producer).
  - A transfer to a non-busy register is legal and writes normally.
  - stall = (rs1 != 0 && busy[rs1]) || (rs2 != 0 && busy[rs2]). It is combinational from registered busy bits and has no forwarding of same-cycle clears.

Optional Feature:
- Macro WB_SCOREBOARD_EN.
- Defined: busy array, issue_valid/issue_rd handling and stall are implemented as above.
- Undefined: no busy storage is built; issue_valid, issue_rd, rs1 and rs2 are ignored; stall is tied to 0.
- The port list is identical in both builds, and arbitration and the write port are unaffected.

Test Plan:
1. Hold reset=0 with alu_valid=mem_valid=1 -> alu_ready=mem_ready=0, rWrite=0, rsWrite=0, dataWrite=0, last_grant=1. Pull reset low mid-write (no clock edge) -> rWrite falls to 0 immediately.
2. Release reset; alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle. Next cycle: rWrite=1, rsWrite=5, dataWrite=0xDEADBEEF, last_grant=0. Following cycle: rWrite=0, rsWrite=5 held.
3. Both valid continuously (ALU rd=1 data=0x11, MEM rd=2 data=0x22) -> grants ALU, MEM, ALU, MEM; rWrite=1 each cycle; rsWrite sequence 1, 2, 1, 2; dataWrite 0x11, 0x22, ...
4. mem_valid=1, mem_rd=0, mem_data=0xFFFFFFFF -> mem_ready=1; next cycle rWrite=0, last_grant=1.
5. (WB_SCOREBOARD_EN) issue_valid=1, issue_rd=7, then rs1=7 -> stall=1. ALU transfer rd=7 -> stall=0 after that edge. issue_rd=7 and MEM transfer rd=7 in the same cycle -> stall stays 1. rs1=rs2=0 -> stall=0 always.
6. (No macro) repeat scenario 5 stimulus -> stall=0 throughout, and write-port behaviour matches scenarios 2–4.
